// File: rtl/samplerz_sched.sv
// Top-level SamplerZ pass sequencer: issues one pre_samp run per complex coefficient,
// then drives the base sampler for the real and imaginary samples, retrying on rejection.
module samplerz_sched #(
  parameter int         ADDR_W       = 16,
  parameter int         RUNS_512     = 256,
  parameter int         RUNS_1024    = 512,
  parameter int         PS_GUARD     = 3,
  parameter logic [3:0] SAMPLERZ_512 = 4'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        task_type,
  input  logic [ADDR_W-1:0] mu_base,
  input  logic [ADDR_W-1:0] isigma_base,
  output logic              ps_start,
  output logic [ADDR_W-1:0] ps_mu_addr,
  output logic [ADDR_W-1:0] ps_isigma_addr,
  input  logic              ps_done,
  output logic              bs_start,
  output logic              bs_sel,
  input  logic              bs_done,
  input  logic              bs_accept,
  output logic [9:0]        run_idx,
  output logic              busy,
  output logic              done
);

  localparam int         GAP_W    = (PS_GUARD < 1) ? 1 : $clog2(PS_GUARD + 1);
  localparam logic [9:0] LAST_512 = 10'(RUNS_512 - 1);
  localparam logic [9:0] LAST_1K  = 10'(RUNS_1024 - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_PS,
    BS_ISSUE,
    WAIT_BS,
    FIN
  } state_t;

  state_t            state, state_d;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic [3:0]        task_q, task_d;
  logic [ADDR_W-1:0] mu_base_q, mu_base_d;
  logic [ADDR_W-1:0] is_base_q, is_base_d;
  logic [9:0]        run_idx_d;
  logic              bs_sel_d;
  logic [9:0]        run_last;

  logic              ps_start_d, bs_start_d, busy_d, done_d;
  logic [ADDR_W-1:0] ps_mu_addr_d, ps_isigma_addr_d;

  assign run_last = (task_q == SAMPLERZ_512) ? LAST_512 : LAST_1K;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state;
    gap_d     = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
    task_d    = task_q;
    mu_base_d = mu_base_q;
    is_base_d = is_base_q;
    run_idx_d = run_idx;
    bs_sel_d  = bs_sel;

    unique case (state)
      IDLE: begin
        if (start) begin
          task_d    = task_type;
          mu_base_d = mu_base;
          is_base_d = isigma_base;
          run_idx_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (gap_cnt == '0) state_d = WAIT_PS;
      end
      WAIT_PS: begin
        if (ps_done) begin
          gap_d    = GAP_W'(PS_GUARD);
          bs_sel_d = 1'b0;
          state_d  = BS_ISSUE;
        end
      end
      BS_ISSUE: state_d = WAIT_BS;
      WAIT_BS: begin
        if (bs_done) begin
          if (!bs_accept) begin
            state_d = BS_ISSUE;
          end else if (!bs_sel) begin
            bs_sel_d = 1'b1;
            state_d  = BS_ISSUE;
          end else if (run_idx != run_last) begin
            run_idx_d = run_idx + 10'd1;
            state_d   = ISSUE;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so each pulse lines up with its state.
  always_comb begin
    ps_start_d       = (state_d == ISSUE) && (gap_d == '0);
    bs_start_d       = (state_d == BS_ISSUE);
    busy_d           = (state_d != IDLE) && (state_d != FIN);
    done_d           = (state_d == FIN);
    ps_mu_addr_d     = ps_mu_addr;
    ps_isigma_addr_d = ps_isigma_addr;
    if (ps_start_d) begin
      ps_mu_addr_d     = mu_base_d + ADDR_W'(run_idx_d);
      ps_isigma_addr_d = is_base_d + ADDR_W'(run_idx_d >> 2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      task_q         <= '0;
      mu_base_q      <= '0;
      is_base_q      <= '0;
      run_idx        <= '0;
      bs_sel         <= 1'b0;
      ps_start       <= 1'b0;
      bs_start       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ps_mu_addr     <= '0;
      ps_isigma_addr <= '0;
    end else begin
      state          <= state_d;
      gap_cnt        <= gap_d;
      task_q         <= task_d;
      mu_base_q      <= mu_base_d;
      is_base_q      <= is_base_d;
      run_idx        <= run_idx_d;
      bs_sel         <= bs_sel_d;
      ps_start       <= ps_start_d;
      bs_start       <= bs_start_d;
      busy           <= busy_d;
      done           <= done_d;
      ps_mu_addr     <= ps_mu_addr_d;
      ps_isigma_addr <= ps_isigma_addr_d;
    end
  end

endmodule

// File: tb/tb_samplerz_sched.sv
// Self-checking bench for samplerz_sched: table of whole passes with pre_samp/base-sampler
// responders, scoreboards for run addresses and bs_sel order, plus a mid-pass reset sequence.
`timescale 1ns/1ps
module tb_samplerz_sched;

  localparam int ADDR_W   = 12;
  localparam int PS_GUARD = 3;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [3:0]        task_type;
  logic [ADDR_W-1:0] mu_base, isigma_base;
  logic              ps_start, ps_done, bs_start, bs_sel, bs_done, bs_accept;
  logic [ADDR_W-1:0] ps_mu_addr, ps_isigma_addr;
  logic [9:0]        run_idx;
  logic              busy, done;

  samplerz_sched #(.ADDR_W(ADDR_W), .PS_GUARD(PS_GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .task_type(task_type),
    .mu_base(mu_base), .isigma_base(isigma_base),
    .ps_start(ps_start), .ps_mu_addr(ps_mu_addr), .ps_isigma_addr(ps_isigma_addr),
    .ps_done(ps_done), .bs_start(bs_start), .bs_sel(bs_sel),
    .bs_done(bs_done), .bs_accept(bs_accept), .run_idx(run_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        tt;
    logic [ADDR_W-1:0] mu;
    logic [ADDR_W-1:0] isg;
    int                bs_lat;
    int                rej;
    int                spur;
    int                exp_ps;
    int                exp_bs;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] mu;
    logic [ADDR_W-1:0] isg;
    logic [9:0]        run;
  } sb_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  sb_t  ps_q[$];
  bit   bs_q[$];
  int   n_ps, n_bs, n_done;
  bit   sb_en = 0;
  int   bs_lat = 1;
  int   rej_left = 0;
  bit   spur = 0;
  int   last_psd = 0;
  bit   psd_valid = 0;
  vec_t tbl[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pre_samp answers 2 cycles after ps_start; base sampler after bs_lat cycles.
  // With spur set, stray done pulses are injected into states that must ignore them.
  initial begin
    int ps_cd = 0;
    int bs_cd = 0;
    ps_done = 0; bs_done = 0; bs_accept = 0;
    forever begin
      @(negedge clk);
      ps_done = 0; bs_done = 0; bs_accept = 0;
      if (!rst_n) begin
        ps_cd = 0;
        bs_cd = 0;
      end else begin
        if (ps_cd > 0) begin
          ps_cd--;
          if (ps_cd == 0) begin
            ps_done   = 1;
            last_psd  = cyc;
            psd_valid = 1;
          end
        end
        if (bs_cd > 0) begin
          bs_cd--;
          if (bs_cd == 0) begin
            bs_done   = 1;
            bs_accept = (rej_left == 0);
            if (rej_left > 0) rej_left--;
          end
        end
        if (ps_start) ps_cd = 2;
        if (bs_start) bs_cd = bs_lat;
        if (spur && ps_start) begin
          bs_done   = 1;
          bs_accept = 1;
        end
        if (spur && bs_start) ps_done = 1;
      end
    end
  end

  // Scoreboard monitor: pops expected run addresses / bs_sel values as the DUT issues pulses.
  initial begin
    sb_t e;
    bit  es;
    forever begin
      @(negedge clk);
      if (rst_n && sb_en) begin
        if (ps_start) begin
          n_ps++;
          if (ps_q.size() == 0) begin
            check("ps_start_unexpected", 64'(ps_q.size()), 64'd1);
          end else begin
            e = ps_q.pop_front();
            check("ps_mu_addr", 64'(ps_mu_addr), 64'(e.mu));
            check("ps_isigma_addr", 64'(ps_isigma_addr), 64'(e.isg));
            check("run_idx", 64'(run_idx), 64'(e.run));
          end
          if (psd_valid) check("ps_guard", 64'(cyc >= last_psd + PS_GUARD + 1), 64'd1);
        end
        if (bs_start) begin
          n_bs++;
          if (bs_q.size() == 0) begin
            check("bs_start_unexpected", 64'(bs_q.size()), 64'd1);
          end else begin
            es = bs_q.pop_front();
            check("bs_sel", 64'(bs_sel), 64'(es));
          end
        end
        if (done) n_done++;
      end
    end
  end

  task automatic run_pass(input vec_t v);
    int  wait_cyc;
    sb_t e;
    ps_q.delete();
    bs_q.delete();
    for (int k = 0; k < v.exp_ps; k++) begin
      e.mu  = v.mu + ADDR_W'(k);
      e.isg = v.isg + ADDR_W'(k >> 2);
      e.run = 10'(k);
      ps_q.push_back(e);
      if (k == 0) for (int r = 0; r < v.rej; r++) bs_q.push_back(1'b0);
      bs_q.push_back(1'b0);
      bs_q.push_back(1'b1);
    end
    n_ps = 0; n_bs = 0; n_done = 0; psd_valid = 0;
    bs_lat = v.bs_lat; rej_left = v.rej; spur = (v.spur != 0); sb_en = 1;
    task_type = v.tt; mu_base = v.mu; isigma_base = v.isg; start = 1;
    @(negedge clk);
    start = 0;
    // Scramble the inputs to show the pass uses only the values latched on start.
    task_type = ~v.tt; mu_base = ~v.mu; isigma_base = ~v.isg;
    check("first_ps_start", 64'(ps_start), 64'd1);
    check("busy_on_start", 64'(busy), 64'd1);
    wait_cyc = 0;
    while (!done && wait_cyc < 20000) begin
      @(negedge clk);
      wait_cyc++;
      start = v.spur != 0 && busy && !done && (wait_cyc % 37 == 0);
    end
    start = 0;
    check("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    check("ps_count", 64'(n_ps), 64'(v.exp_ps));
    check("bs_count", 64'(n_bs), 64'(v.exp_bs));
    check("done_count", 64'(n_done), 64'd1);
    check("ps_sb_left", 64'(ps_q.size()), 64'd0);
    check("bs_sb_left", 64'(bs_q.size()), 64'd0);
    sb_en = 0;
    spur  = 0;
  endtask

  initial begin
    int wait_cyc;
    //          tt     mu       isg      lat rej spur ps   bs
    tbl[0] = '{4'd1, 12'h040, 12'h080, 2,  0,  0,   256, 512};
    tbl[1] = '{4'd2, 12'h200, 12'h010, 1,  0,  1,   512, 1024};
    tbl[2] = '{4'd1, 12'h000, 12'h000, 1,  2,  0,   256, 514};

    rst_n = 0; start = 0; task_type = '0; mu_base = '0; isigma_base = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({ps_start, bs_start, bs_sel, busy, done, run_idx, ps_mu_addr, ps_isigma_addr}), 64'd0);
    rst_n = 1;
    @(negedge clk);

    for (int t = 0; t < 3; t++) run_pass(tbl[t]);

    // Mid-pass reset while waiting on the base sampler in run 7.
    bs_lat = 2; rej_left = 0; spur = 0; sb_en = 0;
    task_type = 4'd1; mu_base = 12'h300; isigma_base = 12'h030; start = 1;
    @(negedge clk);
    start = 0;
    wait_cyc = 0;
    while (!(bs_start && run_idx == 10'd7) && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("run7_reached", 64'(run_idx), 64'd7);
    @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 0;
    #1;
    check("async_reset_outputs",
          64'({ps_start, bs_start, bs_sel, busy, done, run_idx, ps_mu_addr, ps_isigma_addr}), 64'd0);
    @(negedge clk);
    check("no_done_after_reset", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    task_type = 4'd1; mu_base = 12'h500; isigma_base = 12'h060; start = 1;
    @(negedge clk);
    start = 0;
    check("restart_ps_start", 64'(ps_start), 64'd1);
    check("restart_run_idx", 64'(run_idx), 64'd0);
    check("restart_mu_addr", 64'(ps_mu_addr), 64'h500);
    check("restart_isigma_addr", 64'(ps_isigma_addr), 64'h060);
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
